axil_axis_bridge: RTL



---
 rtl/axis_converter_lite_pkg_prm.sv | 41 ++++
 rtl/axil_if.sv | 27 ++
 rtl/axis_fifo_sync.sv | 61 ++++++
 rtl/axil_axis_bridge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_converter_lite_pkg_prm.sv
// Shared constants and types for the AXI-Lite to AXI-Stream bridge.
//   - bus widths, register byte offsets, response codes
//   - write/read channel FSM state types
//   - helpers for write-strobe masking and STATUS count fields
package axis_converter_lite_pkg_prm;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  // Byte offsets within the 16-byte register window (addr[3:2] decoded).
  localparam logic [3:0] REG_TX_DATA = 4'h0;
  localparam logic [3:0] REG_RX_DATA = 4'h4;
  localparam logic [3:0] REG_STATUS  = 4'h8;
  localparam logic [3:0] REG_CTRL    = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Bytes whose strobe is low are forced to 0x00.
  function automatic logic [AXI_DATA_WIDTH-1:0] apply_wstrb(
    input logic [AXI_DATA_WIDTH-1:0] data,
    input logic [AXI_STRB_WIDTH-1:0] strb
  );
    logic [AXI_DATA_WIDTH-1:0] masked;
    masked = '0;
    for (int i = 0; i < AXI_STRB_WIDTH; i++) begin
      if (strb[i]) masked[8*i +: 8] = data[8*i +: 8];
    end
    return masked;
  endfunction

  // STATUS count fields are 8 bits; a 256-deep FIFO saturates at 0xFF when full.
  function automatic logic [7:0] count_field(input logic [8:0] cnt);
    return (cnt > 9'd255) ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bundle between the Lite converter front end and the bridge core.
// Modport m_axil is the bridge's view: address/data/valids/bready/rready in,
// readies/responses/read data out.
interface axil_if;
  logic [axis_converter_lite_pkg_prm::AXI_ADDR_WIDTH-1:0] awaddr;
  logic                                                   awvalid;
  logic                                                   awready;
  logic [axis_converter_lite_pkg_prm::AXI_DATA_WIDTH-1:0] wdata;
  logic [axis_converter_lite_pkg_prm::AXI_STRB_WIDTH-1:0] wstrb;
  logic                                                   wvalid;
  logic                                                   wready;
  logic [1:0]                                             bresp;
  logic                                                   bvalid;
  logic                                                   bready;
  logic [axis_converter_lite_pkg_prm::AXI_ADDR_WIDTH-1:0] araddr;
  logic                                                   arvalid;
  logic                                                   arready;
  logic [axis_converter_lite_pkg_prm::AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                                             rresp;
  logic                                                   rvalid;
  logic                                                   rready;

  modport m_axil (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axis_fifo_sync.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wr_data   write request and data (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   flush           empties the FIFO; a push in the same cycle is discarded
//   rd_data         head word, valid whenever !empty
//   full, empty     occupancy flags
//   count           words held, $clog2(DEPTH)+1 bits
module axis_fifo_sync #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees a slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/axil_axis_bridge.sv
// AXI-Lite register slave bridging to a pair of AXI-Stream ports.
//   0x0 TX_DATA  W : push {LAST_NEXT, wdata} to TX FIFO (SLVERR when full)
//   0x4 RX_DATA  R : pop RX FIFO head (SLVERR when empty)
//   0x8 STATUS   R : {rx_count, tx_count, rx_head_tlast, rx_empty, rx_full, tx_empty, tx_full}
//   0xC CTRL     W : bit0 LAST_NEXT, bit1 RX_FLUSH
// Ports: aclk/areset (sync, active-high), s_axil (AXI-Lite, m_axil modport),
//   m_axis_* TX stream master, s_axis_* RX stream slave,
//   irq (only with AXIL_AXIS_BRIDGE_IRQ_EN; 0x4 writes then load IRQ_MASK).
//
// state  | meaning
// W_IDLE | awready=wready=awvalid&wvalid; push/decode on handshake
// W_RESP | bvalid held until bready
// R_IDLE | arready=1; rdata/rresp captured on handshake
// R_DATA | rvalid held until rready
module axil_axis_bridge
  import axis_converter_lite_pkg_prm::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  axil_if.m_axil                    s_axil,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready
`ifdef AXIL_AXIS_BRIDGE_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                      aw_rdy, b_vld, ar_rdy, r_vld;
  logic [1:0]                bresp_q, rresp_q, rd_resp;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rd_word, wdata_m, status;
  logic [3:0]                wr_reg, rd_reg;
  logic                      aw_hs, ar_hs, last_next;
  logic                      tx_wr, tx_push, tx_pop, ctrl_wr, rx_push, rx_pop, rx_flush;
  logic                      tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_CW-1:0]          tx_count;
  logic [RX_CW-1:0]          rx_count;
  logic [AXI_DATA_WIDTH:0]   tx_head, rx_head;
  logic                      unused_addr;

  assign unused_addr = ^{s_axil.awaddr[AXI_ADDR_WIDTH-1:4], s_axil.awaddr[1:0],
                         s_axil.araddr[AXI_ADDR_WIDTH-1:4], s_axil.araddr[1:0]};

  assign wr_reg  = {s_axil.awaddr[3:2], 2'b00};
  assign rd_reg  = {s_axil.araddr[3:2], 2'b00};
  assign wdata_m = apply_wstrb(s_axil.wdata, s_axil.wstrb);

  assign aw_hs    = (wr_state == W_IDLE) && s_axil.awvalid && s_axil.wvalid;
  assign ar_hs    = (rd_state == R_IDLE) && s_axil.arvalid;
  assign tx_wr    = aw_hs && (wr_reg == REG_TX_DATA) && (s_axil.wstrb != '0);
  assign tx_push  = tx_wr && !tx_full;
  assign tx_pop   = m_axis_tvalid && m_axis_tready;
  assign ctrl_wr  = aw_hs && (wr_reg == REG_CTRL);
  assign rx_flush = ctrl_wr && wdata_m[1];
  assign rx_push  = s_axis_tvalid && s_axis_tready;
  assign rx_pop   = ar_hs && (rd_reg == REG_RX_DATA) && !rx_empty;

  assign m_axis_tvalid = !tx_empty;
  assign m_axis_tdata  = tx_head[AXI_DATA_WIDTH-1:0];
  assign m_axis_tlast  = tx_head[AXI_DATA_WIDTH];
  assign s_axis_tready = !rx_full;

  assign s_axil.awready = aw_rdy;
  assign s_axil.wready  = aw_rdy;
  assign s_axil.bvalid  = b_vld;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = ar_rdy;
  assign s_axil.rvalid  = r_vld;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  axis_fifo_sync #(.WIDTH(AXI_DATA_WIDTH + 1), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push    (tx_push),
    .wr_data ({last_next, wdata_m}),
    .pop     (tx_pop),
    .flush   (1'b0),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  axis_fifo_sync #(.WIDTH(AXI_DATA_WIDTH + 1), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push    (rx_push),
    .wr_data ({s_axis_tlast, s_axis_tdata}),
    .pop     (rx_pop),
    .flush   (rx_flush),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  always_comb begin
    wr_next = wr_state;
    aw_rdy  = 1'b0;
    b_vld   = 1'b0;
    case (wr_state)
      W_IDLE: begin
        aw_rdy = s_axil.awvalid && s_axil.wvalid;
        if (aw_rdy) wr_next = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (s_axil.bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    ar_rdy  = 1'b0;
    r_vld   = 1'b0;
    case (rd_state)
      R_IDLE: begin
        ar_rdy = 1'b1;
        if (s_axil.arvalid) rd_next = R_DATA;
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (s_axil.rready) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[4]     = !rx_empty && rx_head[AXI_DATA_WIDTH];
    status[15:8]  = count_field(9'(tx_count));
    status[23:16] = count_field(9'(rx_count));
  end

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_reg)
      REG_RX_DATA: begin
        if (!rx_empty) rd_word = rx_head[AXI_DATA_WIDTH-1:0];
        else           rd_resp = RESP_SLVERR;
      end
      REG_STATUS: rd_word = status;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state  <= W_IDLE;
      rd_state  <= R_IDLE;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      last_next <= 1'b0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      if (aw_hs) bresp_q <= (tx_wr && tx_full) ? RESP_SLVERR : RESP_OKAY;
      // A dropped push (FIFO full) leaves LAST_NEXT armed for the retry.
      if (tx_push)      last_next <= 1'b0;
      else if (ctrl_wr) last_next <= wdata_m[0];
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_resp;
      end
    end
  end

`ifdef AXIL_AXIS_BRIDGE_IRQ_EN
  logic [2:0] irq_mask;
  logic       rx_last_seen;

  always_ff @(posedge aclk) begin
    if (areset) begin
      irq_mask     <= '0;
      rx_last_seen <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (aw_hs && (wr_reg == REG_RX_DATA)) irq_mask <= wdata_m[2:0];
      // A beat discarded by a concurrent flush does not count as received.
      if (rx_push && s_axis_tlast && !rx_flush)    rx_last_seen <= 1'b1;
      else if (ar_hs && (rd_reg == REG_STATUS))    rx_last_seen <= 1'b0;
      irq <= |(irq_mask & {rx_last_seen, tx_empty, !rx_empty});
    end
  end
`endif

endmodule
